multicycle_processor: RTL

MULTICYCLE_PROCESSOR -- requirements
Module: multicycle_processor

---
 rtl/mc_pkg.sv | 36 +++
 rtl/mc_regfile.sv | 32 +++
 rtl/multicycle_processor.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared types for the multicycle core: opcode and FSM state enums plus
// the fixed bit positions of the instruction fields.
package mc_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_XOR   = 4'h5,
    OP_NOT   = 4'h6,
    OP_LOAD  = 4'h7,
    OP_STORE = 4'h8,
    OP_SHL   = 4'h9,
    OP_SHR   = 4'hA
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM
  } state_e;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RA_MSB  = 11;
  localparam int RA_LSB  = 9;
  localparam int RB_MSB  = 8;
  localparam int RB_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 3;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/mc_regfile.sv
// Eight-entry register file: two combinational read ports, one write port,
// every entry cleared by the asynchronous reset.
module mc_regfile #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        raddrA,
  input  logic [2:0]        raddrB,
  output logic [DATA_W-1:0] rdataA,
  output logic [DATA_W-1:0] rdataB,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs_q [8];

  assign rdataA = regs_q[raddrA];
  assign rdataB = regs_q[raddrB];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/multicycle_processor.sv
// Three-state (IDLE/EXEC/MEM) processor core: accepts one 16-bit instruction
// per IDLE visit, executes ALU ops in one cycle and loads/stores via a held request.
module multicycle_processor
  import mc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] result,
  output logic              illegal
);

  localparam int SH_W = $clog2(DATA_W);

  state_e            state_q;
  logic [15:0]       instr_q;
  logic              memReq_q;
  logic              memWe_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [DATA_W-1:0] memWdata_q;
  logic [DATA_W-1:0] result_q;
  logic              illegal_q;

  opcode_e           op;
  logic [DATA_W-1:0] rdA;
  logic [DATA_W-1:0] rdB;
  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] aluRes;
  logic              isAlu;
  logic              isMem;
  logic              isIllegal;
  logic [ADDR_W-1:0] memAddr_d;
  logic              rfWe;
  logic [2:0]        rfWaddr;
  logic [DATA_W-1:0] rfWdata;

  assign op        = opcode_e'(instr_q[OP_MSB:OP_LSB]);
  assign shamt     = rdB[SH_W-1:0];
  assign memAddr_d = ADDR_W'(rdB) + ADDR_W'($signed(instr_q[IMM_MSB:IMM_LSB]));

  mc_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddrA (instr_q[RA_MSB:RA_LSB]),
    .raddrB (instr_q[RB_MSB:RB_LSB]),
    .rdataA (rdA),
    .rdataB (rdB),
    .we     (rfWe),
    .waddr  (rfWaddr),
    .wdata  (rfWdata)
  );

  always_comb begin
    aluRes    = '0;
    isAlu     = 1'b0;
    isMem     = 1'b0;
    isIllegal = 1'b0;
    case (op)
      OP_NOP:             ;
      OP_ADD:             begin isAlu = 1'b1; aluRes = rdA + rdB;      end
      OP_SUB:             begin isAlu = 1'b1; aluRes = rdA - rdB;      end
      OP_AND:             begin isAlu = 1'b1; aluRes = rdA & rdB;      end
      OP_OR:              begin isAlu = 1'b1; aluRes = rdA | rdB;      end
      OP_XOR:             begin isAlu = 1'b1; aluRes = rdA ^ rdB;      end
      OP_NOT:             begin isAlu = 1'b1; aluRes = ~rdA;           end
      OP_SHL:             begin isAlu = 1'b1; aluRes = rdA << shamt;   end
      OP_SHR:             begin isAlu = 1'b1; aluRes = rdA >> shamt;   end
      OP_LOAD, OP_STORE:  isMem = 1'b1;
      default:            isIllegal = 1'b1;
    endcase
  end

  // ALU results land in rD when EXEC exits; load data lands in rA when MEM is acknowledged.
  always_comb begin
    rfWe    = 1'b0;
    rfWaddr = instr_q[RA_MSB:RA_LSB];
    rfWdata = mem_rdata;
    if (state_q == ST_EXEC && isAlu) begin
      rfWe    = 1'b1;
      rfWaddr = instr_q[RD_MSB:RD_LSB];
      rfWdata = aluRes;
    end else if (state_q == ST_MEM && mem_ack && op == OP_LOAD) begin
      rfWe = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      result_q   <= '0;
      illegal_q  <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      if (rfWe) begin
        result_q <= rfWdata;
      end
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state_q <= ST_IDLE;
          if (isMem) begin
            memReq_q   <= 1'b1;
            memWe_q    <= (op == OP_STORE);
            memAddr_q  <= memAddr_d;
            memWdata_q <= rdA;
            state_q    <= ST_MEM;
          end
          if (isIllegal) begin
            illegal_q <= 1'b1;
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            memReq_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == ST_IDLE) && !rst;
  assign mem_req     = memReq_q;
  assign mem_we      = memWe_q;
  assign mem_addr    = memAddr_q;
  assign mem_wdata   = memWdata_q;
  assign result      = result_q;
  assign illegal     = illegal_q;

endmodule
